// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, PC step sizes and the
// opcode field bounds that the control decoder also uses.
package fetch_pkg;

  typedef enum logic {
    FETCH,
    EXEC
  } fetch_state_e;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned BR_SHIFT = 2;
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 21;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, conditional (branch && zero) or unconditional
// branch target, with the unconditional case taking priority.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic                branch,
  input  logic                uncond_branch,
  input  logic                zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] seq_pc;

  always_comb begin
    target  = pc + (offset << BR_SHIFT);
    seq_pc  = pc + PC_WIDTH'(PC_INC);
    next_pc = seq_pc;
    // Nested if (not an OR of the flags) so an X on branch is never looked at when
    // uncond_branch is set.
    if (uncond_branch) begin
      next_pc = target;
    end else if (branch && zero) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, fetch/exec handshake FSM, instruction register and
// retired-instruction counter.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [10:0]         opcode,
  output logic                instr_valid,
  input  logic                retire,
  input  logic                branch,
  input  logic                uncond_branch,
  input  logic                zero,
  input  logic [PC_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         retired_count
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         count_q, count_d;
  logic [PC_WIDTH-1:0] next_pc;

  next_pc_calc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc_calc (
    .pc           (pc_q),
    .offset       (branch_offset),
    .branch       (branch),
    .uncond_branch(uncond_branch),
    .zero         (zero),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = ~reset;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid = ~reset;
        if (retire) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign opcode        = instr_q[OPC_MSB:OPC_LSB];
  assign retired_count = count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a queue holds the fetch addresses the bench predicts and
// each new fetch pops and compares one. A second instance exercises PC wrap-around.
module tb_pc_fetch;

  logic        CLK = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] branch_offset;

  logic        imem_req, instr_valid;
  logic [63:0] imem_addr, pc;
  logic [31:0] instr, retired_count;
  logic [10:0] opcode;

  logic        imem_req1, instr_valid1;
  logic [63:0] imem_addr1, pc1;
  logic [31:0] instr1, retired_count1;
  logic [10:0] opcode1;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mpc;
  logic [31:0] mcount;

  always #5 CLK = ~CLK;

  pc_fetch #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
    .CLK(CLK), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .retire(retire), .branch(branch),
    .uncond_branch(uncond_branch), .zero(zero), .branch_offset(branch_offset), .pc(pc),
    .retired_count(retired_count)
  );

  pc_fetch #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .CLK(CLK), .reset(reset), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr1), .opcode(opcode1),
    .instr_valid(instr_valid1), .retire(retire), .branch(branch),
    .uncond_branch(uncond_branch), .zero(zero), .branch_offset(branch_offset), .pc(pc1),
    .retired_count(retired_count1)
  );

  function automatic logic [63:0] model_next(input logic [63:0] p, input logic [63:0] off,
                                             input logic ub, input logic br, input logic z);
    if (ub) return p + (off << 2);
    if (br && z) return p + (off << 2);
    return p + 64'd4;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    sb_q.delete();
    mpc    = 64'h0;
    mcount = 32'd0;
    sb_q.push_back(64'h0);
  endtask

  // One full instruction: fetch with `waits` stall cycles, then retire with the given flags.
  task automatic do_instr(input logic [31:0] rd, input logic ub, input logic br,
                          input logic z, input logic [63:0] off, input int waits);
    logic [63:0] exp_addr;
    logic [10:0] exp_opc;
    logic [31:0] rd_v;
    rd_v     = rd;
    exp_opc  = rd_v[31:21];
    exp_addr = 64'hX;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected fetch address queued");
    end else begin
      exp_addr = sb_q.pop_front();
    end
    for (int i = 0; i <= waits; i++) begin
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? rd : 32'hDEAD_BEEF;
      retire     = 1'b1;  // must be ignored in FETCH
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL fetch_req[%0d]: req=%b addr=%h, required req=1 addr=%h",
                 i, imem_req, imem_addr, exp_addr);
      end
      tick();
    end
    imem_ready = 1'b0;
    retire     = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== rd || opcode !== exp_opc) begin
      failures++;
      $display("FAIL exec_instr: valid=%b instr=%h opcode=%h, required 1 %h %h",
               instr_valid, instr, opcode, rd, exp_opc);
    end
    uncond_branch = ub;
    branch        = br;
    zero          = z;
    branch_offset = off;
    retire        = 1'b1;
    imem_ready    = 1'b1;  // must be ignored in EXEC
    imem_rdata    = 32'h1234_5678;
    mpc           = model_next(mpc, off, ub, br, z);
    mcount        = mcount + 32'd1;
    sb_q.push_back(mpc);
    tick();
    retire        = 1'b0;
    imem_ready    = 1'b0;
    uncond_branch = 1'b0;
    branch        = 1'b0;
    zero          = 1'b0;
    #1;
    checks++;
    if (pc !== mpc || retired_count !== mcount || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL retire: pc=%h count=%0d valid=%b, required pc=%h count=%0d valid=0",
               pc, retired_count, instr_valid, mpc, mcount);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b1; retire = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_gate: req=%b valid=%b, required 0 0", imem_req, instr_valid);
    end
    tick();
    checks++;
    if (pc !== 64'h0 || instr !== 32'h0 || retired_count !== 32'h0 || pc1 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL reset_state: pc=%h instr=%h count=%0d pc1=%h, required 0 0 0 fffffffffffffffc",
               pc, instr, retired_count, pc1);
    end
    reset = 1'b0; imem_ready = 1'b0; retire = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_req: req=%b valid=%b, required 1 0", imem_req, instr_valid);
    end
    clear_model();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) do_instr(32'hD280_0000 + i, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    checks++;
    if (retired_count !== 32'd4 || pc !== 64'd16) begin
      failures++;
      $display("FAIL sequential: count=%0d pc=%h, required 4 10", retired_count, pc);
    end
  endtask

  task automatic test_wait_states();
    do_instr(32'h8B02_0020, 1'b0, 1'b0, 1'b0, 64'h0, 3);
  endtask

  task automatic jump_to(input logic [63:0] dest);
    logic [63:0] off;
    off = $signed(dest - mpc) >>> 2;
    do_instr(32'h1400_0000, 1'b1, 1'b0, 1'b0, off, 0);
  endtask

  task automatic test_uncond();
    jump_to(64'h100);
    checks++;
    if (pc !== 64'h100) begin
      failures++;
      $display("FAIL uncond_setup: pc=%h, required 100", pc);
    end
    do_instr(32'h17FF_FFFC, 1'b1, 1'bx, 1'bx, -64'sd4, 0);
    checks++;
    if (pc !== 64'hF0 || $isunknown(pc)) begin
      failures++;
      $display("FAIL uncond_branch: pc=%h, required f0", pc);
    end
  endtask

  task automatic test_cbz();
    jump_to(64'h40);
    do_instr(32'hB400_0060, 1'b0, 1'b1, 1'b1, 64'd3, 0);
    checks++;
    if (pc !== 64'h4C) begin
      failures++;
      $display("FAIL cbz_taken: pc=%h, required 4c", pc);
    end
    jump_to(64'h40);
    do_instr(32'hB400_0060, 1'b0, 1'b1, 1'b0, 64'd3, 0);
    checks++;
    if (pc !== 64'h44) begin
      failures++;
      $display("FAIL cbz_not_taken: pc=%h, required 44", pc);
    end
    do_instr(32'h8B02_0020, 1'b0, 1'b0, 1'b1, 64'd3, 1);
    checks++;
    if (pc !== 64'h48) begin
      failures++;
      $display("FAIL zero_only: pc=%h, required 48", pc);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    do_instr(32'h8B02_0020, 1'b0, 1'b0, 1'b0, 64'h0, 0);
    checks++;
    if (pc1 !== 64'h0 || retired_count1 !== 32'd1) begin
      failures++;
      $display("FAIL wrap: pc1=%h count1=%0d, required 0 1", pc1, retired_count1);
    end
  endtask

  task automatic test_reset_mid_exec();
    test_reset();
    imem_ready = 1'b1; imem_rdata = 32'h8B02_0020;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_exec_setup: valid=%b, required 1", instr_valid);
    end
    reset = 1'b1; retire = 1'b1; uncond_branch = 1'b1; branch_offset = 64'd8;
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_gate: valid=%b, required 0", instr_valid);
    end
    tick();
    reset = 1'b0; retire = 1'b0; uncond_branch = 1'b0;
    #1;
    checks++;
    if (pc !== 64'h0 || retired_count !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_exec: pc=%h count=%0d valid=%b req=%b, required 0 0 0 1",
               pc, retired_count, instr_valid, imem_req);
    end
    clear_model();
    do_instr(32'hD280_0000, 1'b0, 1'b0, 1'b0, 64'h0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; retire = 1'b0;
    branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; branch_offset = '0;
    mpc = '0; mcount = '0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_uncond();
    test_cbz();
    test_wrap();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
